// File: rtl/note_period_ctrl.sv
// Keyboard front end for square_wave: synchronises and debounces 12 note keys and two octave
// buttons, picks the lowest held note, and drives its octave-shifted half period, optionally gliding.
module note_period_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned OCT_MAX         = 3,
  parameter int unsigned GLIDE_DIV       = 10_000,
  parameter int unsigned GLIDE_STEP      = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] key_raw,
  input  logic        oct_up_raw,
  input  logic        oct_dn_raw,
  input  logic        glide_en,
  output logic [27:0] half_wave_period,
  output logic        note_active,
  output logic [3:0]  note_idx,
  output logic [1:0]  octave
);

  localparam int unsigned N_IN = 14;
  localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned TK_W = (GLIDE_DIV > 1) ? $clog2(GLIDE_DIV) : 1;
  localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TK_W-1:0] TICK_LAST = TK_W'(GLIDE_DIV - 1);
  localparam logic [1:0]      OCT_TOP   = 2'(OCT_MAX);
  localparam logic [27:0]     STEP      = 28'(GLIDE_STEP);
  localparam logic [27:0]     RESET_PERIOD = 28'd191110;

  function automatic logic [27:0] base_period(input logic [3:0] idx);
    case (idx)
      4'd0:    base_period = 28'd191110;
      4'd1:    base_period = 28'd180388;
      4'd2:    base_period = 28'd170265;
      4'd3:    base_period = 28'd160705;
      4'd4:    base_period = 28'd151685;
      4'd5:    base_period = 28'd143172;
      4'd6:    base_period = 28'd135139;
      4'd7:    base_period = 28'd127551;
      4'd8:    base_period = 28'd120395;
      4'd9:    base_period = 28'd113636;
      4'd10:   base_period = 28'd107260;
      4'd11:   base_period = 28'd101240;
      default: base_period = 28'd191110;
    endcase
  endfunction

  logic [N_IN-1:0] raw_in;
  logic [N_IN-1:0] sync1_q, sync2_q, deb_q;
  logic [DB_W-1:0] db_cnt_q [N_IN];

  assign raw_in = {oct_dn_raw, oct_up_raw, key_raw};

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
      // NOTE: the counter array is a handful of flops, not a RAM, so clearing it in reset is cheap and required.
      for (int i = 0; i < int'(N_IN); i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q <= raw_in;
      sync2_q <= sync1_q;
      for (int i = 0; i < int'(N_IN); i++) begin
        if (sync2_q[i] == deb_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DB_LAST) begin
          deb_q[i]    <= sync2_q[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + DB_W'(1);
        end
      end
    end
  end

  logic [11:0] deb_keys;
  logic        deb_up, deb_dn, up_prev_q, dn_prev_q;
  logic        any_key;
  logic [3:0]  sel_idx;

  assign deb_keys = deb_q[11:0];
  assign deb_up   = deb_q[12];
  assign deb_dn   = deb_q[13];
  assign any_key  = |deb_keys;

  // NOTE: assigning the default first keeps this block purely combinational (no latch).
  always_comb begin
    sel_idx = '0;
    // Walk downward so the lowest held index overwrites the rest.
    for (int i = 11; i >= 0; i--) begin
      if (deb_keys[i]) sel_idx = 4'(i);
    end
  end

  logic        up_edge, dn_edge;
  logic [27:0] target_q;

  assign up_edge = deb_up & ~up_prev_q;
  assign dn_edge = deb_dn & ~dn_prev_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      up_prev_q   <= 1'b0;
      dn_prev_q   <= 1'b0;
      octave      <= '0;
      note_active <= 1'b0;
      note_idx    <= '0;
      target_q    <= RESET_PERIOD;
    end else begin
      up_prev_q   <= deb_up;
      dn_prev_q   <= deb_dn;
      note_active <= any_key;
      if (up_edge && !dn_edge && octave < OCT_TOP) octave <= octave + 2'd1;
      else if (dn_edge && !up_edge && octave != 2'd0) octave <= octave - 2'd1;
      // With no key held the last note and target are kept.
      if (any_key) begin
        note_idx <= sel_idx;
        target_q <= base_period(sel_idx) >> octave;
      end
    end
  end

  logic [TK_W-1:0] tick_q;
  logic            tick;
  logic [27:0]     diff_up, diff_dn, step_up, step_dn;

  assign tick = (tick_q == TICK_LAST);

  // Both differences are formed before stepping, so neither direction can wrap or overshoot.
  always_comb begin
    diff_up = target_q - half_wave_period;
    diff_dn = half_wave_period - target_q;
    step_up = (diff_up > STEP) ? STEP : diff_up;
    step_dn = (diff_dn > STEP) ? STEP : diff_dn;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tick_q           <= '0;
      half_wave_period <= RESET_PERIOD;
    end else begin
      tick_q <= tick ? '0 : tick_q + TK_W'(1);
      if (!glide_en) begin
        half_wave_period <= target_q;
      end else if (tick) begin
        if (half_wave_period < target_q)      half_wave_period <= half_wave_period + step_up;
        else if (half_wave_period > target_q) half_wave_period <= half_wave_period - step_dn;
      end
    end
  end

endmodule
